ecc_dec_stage: RTL

//  SECDED decoder for the codewords produced by the encoder path (modes 4/4, 11/5, 26/6).

---
 rtl/ecc_pkg.sv | 89 ++++++++
 rtl/ecc_syndrome_calc.sv | 21 ++
 rtl/ecc_dec_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: modes, status codes and extended-Hamming H matrices
// (row 0 = overall parity, parity bits at the low end of the codeword, info above).
package ecc_pkg;

    localparam int ECC_CW_W      = 32;
    localparam int ECC_INFO_W    = 26;
    localparam int ECC_PAR_W     = ECC_CW_W - ECC_INFO_W;
    localparam int ECC_MIN_PAR_W = 4;

    typedef enum logic [1:0] {
        MODE_8       = 2'b00,
        MODE_16      = 2'b01,
        MODE_32      = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_CORR    = 2'b01,
        ST_DOUBLE  = 2'b10,
        ST_ILLEGAL = 2'b11
    } status_e;

    typedef logic [ECC_PAR_W-1:0][ECC_CW_W-1:0] hmat_t;

    function automatic int parity_width(input mode_e m);
        case (m)
            MODE_8:  return 4;
            MODE_16: return 5;
            MODE_32: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic int info_width(input mode_e m);
        case (m)
            MODE_8:  return 4;
            MODE_16: return 11;
            MODE_32: return 26;
            default: return 0;
        endcase
    endfunction

    // Parity bit k checks syndrome row k alone; info columns take every pattern of
    // weight >= 2 in ascending order, so all columns are distinct and nonzero.
    function automatic hmat_t build_h(input mode_e m);
        hmat_t h;
        int    p;
        int    n;
        int    pos;
        int    ones;
        h = '0;
        p = parity_width(m);
        n = p + info_width(m);
        if (p > 0) begin
            for (int k = 0; k < p; k++) begin
                h[0][k] = 1'b1;
                if (k > 0) h[k][k] = 1'b1;
            end
            pos = p;
            for (int v = 0; v < (1 << (p - 1)); v++) begin
                ones = 0;
                for (int b = 0; b < 5; b++) begin
                    if (v[b]) ones++;
                end
                if (ones >= 2 && pos < n) begin
                    h[0][pos] = 1'b1;
                    for (int r = 1; r < p; r++) h[r][pos] = v[r-1];
                    pos++;
                end
            end
        end
        return h;
    endfunction

    localparam hmat_t ECC_H_8  = build_h(MODE_8);
    localparam hmat_t ECC_H_16 = build_h(MODE_16);
    localparam hmat_t ECC_H_32 = build_h(MODE_32);

    function automatic hmat_t h_for_mode(input mode_e m);
        case (m)
            MODE_8:  return ECC_H_8;
            MODE_16: return ECC_H_16;
            MODE_32: return ECC_H_32;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome: each bit is the XOR of the codeword bits selected by one H row.
module ecc_syndrome_calc
    import ecc_pkg::*;
(
    input  logic [ECC_CW_W-1:0]  i_codeword,
    input  mode_e                i_mode,
    output logic [ECC_PAR_W-1:0] o_syndrome
);

    hmat_t w_h;

    assign w_h = h_for_mode(i_mode);

    genvar gi;
    generate
        for (gi = 0; gi < ECC_PAR_W; gi++) begin : g_row
            assign o_syndrome[gi] = ^(w_h[gi] & i_codeword);
        end
    endgenerate

endmodule

// File: rtl/ecc_dec_stage.sv
// Two-stage SECDED decoder: S1 registers codeword+syndrome, S2 corrects and extracts info.
// Optional error counters are built when ECC_DEC_ERR_CNT_EN is defined.
module ecc_dec_stage
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    num_of_errors,
    output logic                          out_valid,
`ifdef ECC_DEC_ERR_CNT_EN
    output logic [15:0]                   corr_cnt,
    output logic [15:0]                   uncorr_cnt,
`endif
    input  logic                          out_ready
);

    localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

    logic                                      w_en;
    logic [MAX_PARITY_WIDTH-1:0]               w_syn;
    logic                                      r_s1_valid;
    logic [MAX_CODEWORD_WIDTH-1:ECC_MIN_PAR_W] r_s1_cw;
    mode_e                                     r_s1_mode;
    logic [MAX_PARITY_WIDTH-1:0]               r_s1_syn;
    hmat_t                                     w_h2;
    logic [MAX_CODEWORD_WIDTH-1:0]             w_match;
    logic [MAX_CODEWORD_WIDTH-1:ECC_MIN_PAR_W] w_fixed;
    logic [MAX_CODEWORD_WIDTH-1:0]             w_info;
    status_e                                   w_status;
    logic                                      r_out_valid;
    logic [MAX_CODEWORD_WIDTH-1:0]             r_data_out;
    status_e                                   r_status;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    ecc_syndrome_calc u_syndrome (
        .i_codeword (data_in),
        .i_mode     (mode_e'(mod)),
        .o_syndrome (w_syn)
    );

    // Parity bits below ECC_MIN_PAR_W are only needed for the syndrome, so they are not kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_mode  <= MODE_8;
            r_s1_syn   <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cw   <= data_in[MAX_CODEWORD_WIDTH-1:ECC_MIN_PAR_W];
                r_s1_mode <= mode_e'(mod);
                r_s1_syn  <= w_syn;
            end
        end
    end

    assign w_h2 = h_for_mode(r_s1_mode);

    genvar gi, gj;
    generate
        for (gi = 0; gi < MAX_CODEWORD_WIDTH; gi++) begin : g_col
            logic [MAX_PARITY_WIDTH-1:0] w_col;
            for (gj = 0; gj < MAX_PARITY_WIDTH; gj++) begin : g_bit
                assign w_col[gj] = w_h2[gj][gi];
            end
            assign w_match[gi] = (w_col == r_s1_syn);
        end
    endgenerate

    // With syn[0]=1 only in-mode columns can match, and at most one does.
    always_comb begin
        w_status = ST_NONE;
        w_fixed  = r_s1_cw;
        w_info   = '0;
        if (r_s1_mode == MODE_ILLEGAL) begin
            w_status = ST_ILLEGAL;
        end else if (r_s1_syn == '0) begin
            w_status = ST_NONE;
        end else if (r_s1_syn[0] && (|w_match)) begin
            w_status = ST_CORR;
            w_fixed  = r_s1_cw ^ w_match[MAX_CODEWORD_WIDTH-1:ECC_MIN_PAR_W];
        end else begin
            w_status = ST_DOUBLE;
        end
        case (r_s1_mode)
            MODE_8:  w_info[3:0]  = w_fixed[7:4];
            MODE_16: w_info[10:0] = w_fixed[15:5];
            MODE_32: w_info[25:0] = w_fixed[31:6];
            default: w_info       = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_status    <= ST_NONE;
        end else if (w_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_data_out <= w_info;
                r_status   <= w_status;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign data_out      = r_data_out;
    assign num_of_errors = r_status;

`ifdef ECC_DEC_ERR_CNT_EN
    logic        w_fire;
    logic [15:0] r_corr_cnt;
    logic [15:0] r_uncorr_cnt;

    assign w_fire = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_fire) begin
            if (r_status == ST_CORR && r_corr_cnt != 16'hFFFF)
                r_corr_cnt <= r_corr_cnt + 16'd1;
            if (r_status == ST_DOUBLE && r_uncorr_cnt != 16'hFFFF)
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`endif

endmodule
